// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int LSU_ADDR_W    = 10;
  localparam int LSU_MEM_WORDS = 1 << LSU_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    LAST,
    RESP
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return funct3 inside {SB, SH, SW};
    return funct3 inside {LB, LH, LW, LBU, LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: lane mask, lane-positioned store data and extended load result.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [63:0] load_raw_i,
  output logic [7:0]  lane_mask_o,
  output logic [63:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [3:0]  base_mask;
  logic [31:0] load_window;

  always_comb begin
    case (funct3_i[1:0])
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase

    lane_mask_o  = {4'b0000, base_mask} << offset_i;
    store_data_o = {32'b0, store_data_i} << {offset_i, 3'b000};
    // The two captured words form a 64-bit window; the access starts at byte offset_i.
    load_window  = 32'(load_raw_i >> {offset_i, 3'b000});

    case (funct3_i)
      LB:      load_data_o = {{24{load_window[7]}}, load_window[7:0]};
      LH:      load_data_o = {{16{load_window[15]}}, load_window[15:0]};
      LBU:     load_data_o = {24'b0, load_window[7:0]};
      LHU:     load_data_o = {16'b0, load_window[15:0]};
      default: load_data_o = load_window;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory master: splits misaligned accesses into two word accesses and
// returns aligned, extended load data one transaction at a time.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = LSU_ADDR_W,
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  output logic              resp_valid_o,
  output logic [31:0]       load_data_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  lsu_state_e        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;
  logic [ADDR_W-1:0] word0_q, word0_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;

  logic [2:0]        acc_size;
  logic              acc_split;
  logic              acc_err;
  logic              rd_req, wr_req;

  logic [7:0]        lane_mask;
  logic [63:0]       sdata_sh;
  logic [31:0]       load_ext;

  always_comb begin
    acc_size  = size_bytes(funct3_i);
    acc_split = ({1'b0, addr_i[1:0]} + acc_size) > 3'd4;
    // A split access at the top word would wrap to word 0, so it is refused.
    acc_err   = (|addr_i[31:ADDR_W+2])
             || (acc_split && (addr_i[ADDR_W+1:2] == ADDR_W'(MEM_WORDS - 1)))
             || !funct3_legal(is_store_i, funct3_i);
  end

  lsu_align u_align (
    .offset_i     (offset_q),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .load_raw_i   ({hi_q, lo_q}),
    .lane_mask_o  (lane_mask),
    .store_data_o (sdata_sh),
    .load_data_o  (load_ext)
  );

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path infers a latch.
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    word0_d      = word0_q;
    split_d      = split_q;
    err_d        = err_q;
    sdata_d      = sdata_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    err_o        = 1'b0;
    load_data_o  = '0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = '0;
    mem_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          is_store_d = is_store_i;
          funct3_d   = funct3_i;
          offset_d   = addr_i[1:0];
          word0_d    = addr_i[ADDR_W+1:2];
          split_d    = acc_split;
          err_d      = acc_err;
          sdata_d    = store_data_i;
          lo_d       = '0;
          hi_d       = '0;
          state_d    = acc_err ? RESP : ACC0;
        end
      end

      ACC0: begin
        mem_addr_o = word0_q;
        if (is_store_q) begin
          wr_req      = 1'b1;
          mem_be_o    = lane_mask[3:0];
          mem_wdata_o = sdata_sh[31:0];
        end else begin
          rd_req = 1'b1;
        end
        if (split_q)         state_d = ACC1;
        else if (is_store_q) state_d = RESP;
        else                 state_d = LAST;
      end

      ACC1: begin
        mem_addr_o = word0_q + ADDR_W'(1);
        if (is_store_q) begin
          wr_req      = 1'b1;
          mem_be_o    = lane_mask[7:4];
          mem_wdata_o = sdata_sh[63:32];
          state_d     = RESP;
        end else begin
          rd_req  = 1'b1;
          lo_d    = mem_rdata_i;
          state_d = LAST;
        end
      end

      LAST: begin
        if (split_q) hi_d = mem_rdata_i;
        else         lo_d = mem_rdata_i;
        state_d = RESP;
      end

      RESP: begin
        resp_valid_o = 1'b1;
        err_o        = err_q;
        load_data_o  = (is_store_q || err_q) ? 32'b0 : load_ext;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Strobes drop as soon as reset is seen so an interrupted split never touches word1.
    mem_read_o  = rd_req && !reset_i;
    mem_write_o = wr_req && !reset_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      word0_q    <= '0;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
      sdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      word0_q    <= word0_d;
      split_q    <= split_d;
      err_q      <= err_d;
      sdata_q    <= sdata_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

  localparam int ADDR_W    = 10;
  localparam int MEM_WORDS = 1024;
  localparam int MEM_BYTES = MEM_WORDS * 4;

  logic              clk_i;
  logic              reset_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              is_store_i;
  logic [2:0]        funct3_i;
  logic [31:0]       addr_i;
  logic [31:0]       store_data_i;
  logic              resp_valid_o;
  logic [31:0]       load_data_o;
  logic              err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .resp_valid_o (resp_valid_o),
    .load_data_o  (load_data_o),
    .err_o        (err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int proto_bad = 0;
  int ready_busy_bad = 0;

  // Memory seen by the DUT, and an independent byte-level reference image.
  logic [31:0] mem_words [MEM_WORDS];
  logic [7:0]  model_mem [MEM_BYTES];

  always @(posedge clk_i) begin
    if (mem_write_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem_words[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
    if (mem_read_o) mem_rdata_i <= mem_words[mem_addr_o];
  end

  always @(negedge clk_i) begin
    if (mem_read_o && mem_write_o) proto_bad++;
    if (resp_valid_o && (mem_read_o || mem_write_o)) proto_bad++;
    if (!reset_i && !mem_write_o && !mem_read_o && mem_be_o != 4'b0) proto_bad++;
  end

  // Observed transaction
  int                obs_lat;
  logic              obs_err;
  logic [31:0]       obs_data;
  int                obs_n;
  logic [ADDR_W-1:0] obs_addr [4];
  logic              obs_rd   [4];
  logic              obs_wr   [4];
  logic [3:0]        obs_be   [4];
  logic [31:0]       obs_wd   [4];

  // Expected transaction
  int                exp_lat;
  logic              exp_err;
  logic [31:0]       exp_data;
  int                exp_n;
  logic [ADDR_W-1:0] exp_addr [4];
  logic [3:0]        exp_be   [4];
  logic [31:0]       exp_wd   [4];

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    mem_words[w] = v;
    for (int b = 0; b < 4; b++) model_mem[4*w+b] = v[8*b +: 8];
  endtask

  task automatic init_mem();
    for (int w = 0; w < MEM_WORDS; w++) set_word(w, $urandom);
  endtask

  // Reference: byte-granular access computed straight from address, width and sign rules.
  task automatic model_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data);
    int          s;
    int          first_w, last_w;
    logic        legal;
    logic [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    s = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_err  = !legal || ((longint'(addr) + longint'(s)) > longint'(MEM_BYTES));
    exp_n    = 0;
    exp_data = '0;
    if (exp_err) begin
      exp_lat = 1;
      return;
    end
    first_w = int'(addr) / 4;
    last_w  = (int'(addr) + s - 1) / 4;
    exp_n   = last_w - first_w + 1;
    for (int i = 0; i < exp_n; i++) begin
      exp_addr[i] = ADDR_W'(first_w + i);
      exp_be[i]   = '0;
      exp_wd[i]   = '0;
    end
    v = '0;
    for (int k = 0; k < s; k++) begin
      int ba;
      int wi;
      int ln;
      ba = int'(addr) + k;
      wi = ba / 4 - first_w;
      ln = ba % 4;
      if (st) begin
        exp_be[wi][ln]         = 1'b1;
        exp_wd[wi][8*ln +: 8]  = data[8*k +: 8];
        model_mem[ba]          = data[8*k +: 8];
      end else begin
        v[8*k +: 8] = model_mem[ba];
      end
    end
    if (st) begin
      exp_lat = 1 + exp_n;
    end else begin
      exp_lat = 2 + exp_n;
      case (f3)
        3'd0:    exp_data = {{24{v[7]}}, v[7:0]};
        3'd1:    exp_data = {{16{v[15]}}, v[15:0]};
        3'd4:    exp_data = {24'b0, v[7:0]};
        3'd5:    exp_data = {16'b0, v[15:0]};
        default: exp_data = v;
      endcase
    end
  endtask

  // Issue one request and record strobes and response; busy cycles get random request noise.
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data);
    int wait_cnt;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    is_store_i   = st;
    funct3_i     = f3;
    addr_i       = addr;
    store_data_i = data;
    wait_cnt = 0;
    while (!req_ready_o && wait_cnt < 10) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    @(posedge clk_i);
    #1;
    is_store_i   = 1'($urandom);
    funct3_i     = 3'($urandom);
    addr_i       = $urandom;
    store_data_i = $urandom;
    obs_lat  = -1;
    obs_n    = 0;
    obs_err  = 1'bx;
    obs_data = 'x;
    for (int c = 1; c <= 8 && obs_lat < 0; c++) begin
      @(negedge clk_i);
      if (req_ready_o) ready_busy_bad++;
      if (mem_read_o || mem_write_o) begin
        if (obs_n < 4) begin
          obs_addr[obs_n] = mem_addr_o;
          obs_rd[obs_n]   = mem_read_o;
          obs_wr[obs_n]   = mem_write_o;
          obs_be[obs_n]   = mem_be_o;
          obs_wd[obs_n]   = mem_wdata_o;
        end
        obs_n++;
      end
      if (resp_valid_o) begin
        obs_lat  = c;
        obs_err  = err_o;
        obs_data = load_data_o;
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    req_valid_i = 1'b0;
    is_store_i  = 1'b0;
    funct3_i    = '0;
    addr_i      = '0;
    store_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({resp_valid_o, err_o, load_data_o, mem_read_o, mem_write_o, mem_be_o, mem_wdata_o,
         mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got resp=%b err=%b data=%h rd=%b wr=%b be=%b wd=%h addr=%h, expected all zero",
               resp_valid_o, err_o, load_data_o, mem_read_o, mem_write_o, mem_be_o, mem_wdata_o, mem_addr_o);
    end
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", req_ready_o);
    end
  endtask

  task automatic test_aligned_store();
    model_txn(1'b1, 3'd2, 32'h010, 32'hDEADBEEF);
    do_txn(1'b1, 3'd2, 32'h010, 32'hDEADBEEF);
    n_checks++;
    if (obs_n !== 1 || obs_addr[0] !== 10'd4 || obs_wr[0] !== 1'b1 || obs_be[0] !== 4'b1111
        || obs_wd[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_strobe: got n=%0d addr=%0d wr=%b be=%b wd=%h expected n=1 addr=4 wr=1 be=1111 wd=deadbeef",
               obs_n, obs_addr[0], obs_wr[0], obs_be[0], obs_wd[0]);
    end
    n_checks++;
    if (obs_lat !== 2 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_resp: got lat=%0d err=%b expected lat=2 err=0", obs_lat, obs_err);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [3];
    logic [31:0] adrs [3];
    logic [31:0] want [3];
    f3s  = '{3'd0, 3'd4, 3'd1};
    adrs = '{32'h013, 32'h013, 32'h012};
    want = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    set_word(4, 32'h80FF1234);
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, f3s[i], adrs[i], 32'h0);
      n_checks++;
      if (obs_lat !== 3 || obs_err !== 1'b0 || obs_data !== want[i]) begin
        n_fail++;
        $display("FAIL load_extend[%0d]: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h",
                 i, obs_lat, obs_err, obs_data, want[i]);
      end
    end
  endtask

  task automatic test_split_load();
    set_word(3, 32'hAABBCCDD);
    set_word(4, 32'h11223344);
    do_txn(1'b0, 3'd2, 32'h00E, 32'h0);
    n_checks++;
    if (obs_n !== 2 || obs_addr[0] !== 10'd3 || obs_addr[1] !== 10'd4 || obs_rd[0] !== 1'b1
        || obs_rd[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL split_load_reads: got n=%0d addr0=%0d addr1=%0d rd=%b%b expected n=2 3,4 rd=11",
               obs_n, obs_addr[0], obs_addr[1], obs_rd[0], obs_rd[1]);
    end
    n_checks++;
    if (obs_lat !== 4 || obs_data !== 32'h3344AABB || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL split_load_data: got lat=%0d err=%b data=%h expected lat=4 err=0 data=3344aabb",
               obs_lat, obs_err, obs_data);
    end
  endtask

  task automatic test_split_store();
    model_txn(1'b1, 3'd1, 32'h00F, 32'h0000BEEF);
    do_txn(1'b1, 3'd1, 32'h00F, 32'h0000BEEF);
    n_checks++;
    if (obs_n !== 2 || obs_addr[0] !== 10'd3 || obs_be[0] !== 4'b1000 || obs_wd[0] !== 32'hEF000000
        || obs_addr[1] !== 10'd4 || obs_be[1] !== 4'b0001 || obs_wd[1] !== 32'h000000BE) begin
      n_fail++;
      $display("FAIL split_store_strobes: got n=%0d [%0d %b %h] [%0d %b %h] expected n=2 [3 1000 ef000000] [4 0001 000000be]",
               obs_n, obs_addr[0], obs_be[0], obs_wd[0], obs_addr[1], obs_be[1], obs_wd[1]);
    end
    n_checks++;
    if (obs_lat !== 3 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL split_store_resp: got lat=%0d err=%b expected lat=3 err=0", obs_lat, obs_err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] adrs [3];
    logic [2:0]  f3s  [3];
    adrs = '{32'h00000FFE, 32'h00001000, 32'h00000020};
    f3s  = '{3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, f3s[i], adrs[i], 32'h0);
      n_checks++;
      if (obs_n !== 0 || obs_lat !== 1 || obs_err !== 1'b1 || obs_data !== 32'h0) begin
        n_fail++;
        $display("FAIL error_case[%0d]: got strobes=%0d lat=%0d err=%b data=%h expected strobes=0 lat=1 err=1 data=0",
                 i, obs_n, obs_lat, obs_err, obs_data);
      end
    end
  endtask

  task automatic test_reset_mid_split();
    set_word(3, 32'h01020304);
    set_word(4, 32'h05060708);
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    is_store_i   = 1'b1;
    funct3_i     = 3'd1;
    addr_i       = 32'h00F;
    store_data_i = 32'h0000BEEF;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 10'd3 || mem_be_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_split_first: got wr=%b addr=%0d be=%b expected wr=1 addr=3 be=1000",
               mem_write_o, mem_addr_o, mem_be_o);
    end
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({resp_valid_o, err_o, load_data_o, mem_read_o, mem_write_o, mem_be_o, mem_wdata_o,
         mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_split_outputs: got resp=%b err=%b data=%h rd=%b wr=%b be=%b wd=%h addr=%h, expected all zero",
               resp_valid_o, err_o, load_data_o, mem_read_o, mem_write_o, mem_be_o, mem_wdata_o, mem_addr_o);
    end
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_split_ready: got %b expected 1", req_ready_o);
    end
    model_mem[15] = 8'hEF;
    n_checks++;
    if (mem_words[3] !== 32'hEF020304 || mem_words[4] !== 32'h05060708) begin
      n_fail++;
      $display("FAIL rst_split_memory: got w3=%h w4=%h expected w3=ef020304 w4=05060708",
               mem_words[3], mem_words[4]);
    end
  endtask

  task automatic test_random();
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          r;
    logic [2:0]  load_f3 [5];
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    repeat (80) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = load_f3[$urandom_range(0, 4)];
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom | 32'h00001000;
      else if (r == 1) addr = 32'(4092 + $urandom_range(0, 3));
      else             addr = 32'($urandom_range(0, MEM_BYTES - 1));
      data = $urandom;
      model_txn(st, f3, addr, data);
      do_txn(st, f3, addr, data);
      n_checks++;
      if (obs_lat !== exp_lat || obs_err !== exp_err || obs_data !== exp_data) begin
        n_fail++;
        $display("FAIL rand_resp st=%b f3=%0d addr=%h: got lat=%0d err=%b data=%h expected lat=%0d err=%b data=%h",
                 st, f3, addr, obs_lat, obs_err, obs_data, exp_lat, exp_err, exp_data);
      end
      n_checks++;
      if (obs_n !== exp_n) begin
        n_fail++;
        $display("FAIL rand_strobe_count st=%b f3=%0d addr=%h: got %0d expected %0d",
                 st, f3, addr, obs_n, exp_n);
      end
      for (int i = 0; i < exp_n && i < obs_n && i < 4; i++) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || {obs_rd[i], obs_wr[i]} !== {!st, st}) begin
          n_fail++;
          $display("FAIL rand_access[%0d] addr=%h: got word=%0d rd=%b wr=%b expected word=%0d rd=%b wr=%b",
                   i, addr, obs_addr[i], obs_rd[i], obs_wr[i], exp_addr[i], !st, st);
        end
        if (st) begin
          n_checks++;
          if (obs_be[i] !== exp_be[i] || (obs_wd[i] & lane_bits(exp_be[i])) !== exp_wd[i]) begin
            n_fail++;
            $display("FAIL rand_store_lanes[%0d] f3=%0d addr=%h: got be=%b wd=%h expected be=%b lanes=%h",
                     i, f3, addr, obs_be[i], obs_wd[i], exp_be[i], exp_wd[i]);
          end
        end
      end
    end
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int w = 0; w < MEM_WORDS; w++)
      if (mem_words[w] !== {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]})
        bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL memory_image: got %0d differing words expected 0", bad);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (proto_bad !== 0) begin
      n_fail++;
      $display("FAIL strobe_protocol: got %0d violations expected 0", proto_bad);
    end
    n_checks++;
    if (ready_busy_bad !== 0) begin
      n_fail++;
      $display("FAIL ready_while_busy: got %0d cycles expected 0", ready_busy_bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    is_store_i   = 1'b0;
    funct3_i     = '0;
    addr_i       = '0;
    store_data_i = '0;
    init_mem();
    test_reset();
    test_aligned_store();
    test_load_extend();
    test_split_load();
    test_split_store();
    test_errors();
    test_reset_mid_split();
    test_random();
    test_memory_image();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side master for the core's word-addressed data memory. It accepts one load or store request from the execute stage per transaction and converts byte addresses and RISC-V funct3 widths into word accesses with byte enables. Misaligned accesses that cross a word boundary are split into two memory accesses. Load data is aligned and sign- or zero-extended before it is returned to the writeback stage.

Parameters:
ADDR_W, 10, word-address width of the data memory port
MEM_WORDS, 1024, number of 32-bit words; must equal 2**ADDR_W

Ports:
clk_i  input  1  clock; all state changes on the rising edge
reset_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  high only in IDLE; a request is accepted when req_valid_i && req_ready_o
is_store_i  input  1  1 = store, 0 = load
funct3_i  input  3  LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
addr_i  input  32  byte address from the ALU
store_data_i  input  32  store operand, right-justified
resp_valid_o  output  1  one-cycle pulse that completes the transaction
load_data_o  output  32  extended load result; valid with resp_valid_o, 0 for stores and errors
err_o  output  1  valid with resp_valid_o: range error or illegal funct3
mem_addr_o  output  ADDR_W  word address
mem_read_o  output  1  read strobe
mem_write_o  output  1  write strobe
mem_be_o  output  4  byte-lane enables for writes
mem_wdata_o  output  32  lane-positioned write data
mem_rdata_i  input  32  read data, registered; valid the cycle after mem_read_o

Behaviour:
- Reset (synchronous, active-high): state becomes IDLE. resp_valid_o, err_o, load_data_o, mem_read_o, mem_write_o, mem_be_o, mem_wdata_o and mem_addr_o all reset to 0. req_ready_o is 1 in the first cycle after reset is released.
- At acceptance (cycle T), latch the request. Derive:
  - offset o = addr[1:0]
  - size s = 1, 2 or 4 bytes
  - word0 = addr[ADDR_W+1:2]
  - split = (o + s > 4)
- Error check at acceptance:
  - error if addr[31:ADDR_W+2] != 0, or split && word0 == MEM_WORDS-1 (no wrap-around), or funct3 is illegal (load 3/6/7, store >= 3)
  - on error: no memory strobe is issued; go to RESP with err_o=1 and load_data_o=0.
- Lane mask: m = ((1<<s)-1) << o, 8 bits wide. Word0 uses m[3:0], word1 uses m[7:4].
- Store data: the 64-bit value {32'b0, store_data_i} << 8*o. Word0 takes the low half, word1 the high half.
- States:
  - IDLE: accept a request, then go to ACC0 (or RESP on error).
  - ACC0: drive word0. A store asserts mem_write_o with the word0 lanes; a load asserts mem_read_o. Next state is ACC1 if split, else LAST for loads, else RESP.
  - ACC1: drive word0+1 with the word1 lanes or a read. For loads, capture mem_rdata_i into lo. Next state is LAST for loads, RESP for stores.
  - LAST: capture mem_rdata_i into hi (or into lo when the access is not split). No strobes. Next state is RESP.
  - RESP: resp_valid_o=1 for exactly one cycle. load_data_o = ({hi,lo} >> 8*o) truncated to s bytes, sign-extended for LB/LH, zero-extended for LBU/LHU. Next state is IDLE.
- Latency from acceptance at T to resp_valid_o:
  - aligned store: T+2
  - split store: T+3
  - aligned load: T+3
  - split load: T+4
  - error: T+1
- Strobe rules: mem_read_o and mem_write_o are never high together. Strobes are asserted only in ACC0 and ACC1. Outside those states, mem_be_o is 0.
- req_valid_i is ignored outside IDLE; there is exactly one outstanding transaction.
- Reset mid-operation: the next edge returns to IDLE and no further strobes are issued. A split store interrupted after ACC0 leaves word0 written and word1 unchanged.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum for states: IDLE, ACC0, ACC1, LAST, RESP
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW
  - MEM_WORDS default
- Sub-module lsu_align: purely combinational. Given offset, funct3 and data, it produces the lane mask, the 64-bit shifted store data, and the extended load result. The FSM and all registers stay in load_store_unit.

Test Plan:
- SW at 0x010 with data 0xDEADBEEF: at T+1, mem_addr=4, mem_write=1, be=1111, wdata=0xDEADBEEF; resp_valid at T+2 with err=0.
- Memory word 4 = 0x80FF1234. LB at 0x013 returns 0xFFFFFF80 at T+3; LBU at 0x013 returns 0x00000080; LH at 0x012 returns 0xFFFF80FF.
- Word 3 = 0xAABBCCDD, word 4 = 0x11223344. LW at 0x00E: read word 3 at T+1, read word 4 at T+2; load_data=0x3344AABB at T+4.
- SH at 0x00F with data 0x0000BEEF: at T+1, addr 3, be=1000, wdata=0xEF000000; at T+2, addr 4, be=0001, wdata=0x000000BE; resp at T+3.
- Error cases, each with no strobe and resp at T+1 with err=1, load_data=0:
  - LW at 0x00000FFE
  - LW at 0x00001000
  - load with funct3=3
- Split store at 0x00F with reset_i asserted during cycle T+2: word 3 is written, no write to word 4, all outputs are 0 next cycle, and req_ready_o=1 after reset is released.
